// File: rtl/hr_bridge_param.sv
// Hierarchical-ring bridge: per-lane up/down transfer FIFOs between a local and a global ring,
// with deflection-on-full, empty-slot injection, starvation flags and saturating deflection counters.
module hr_bridge_param #(
    parameter int W          = 144,
    parameter int LANES      = 2,
    parameter int DEPTH      = 4,
    parameter int RING_W     = 4,
    parameter int DST_LSB    = 4,
    parameter int LOCAL_RING = 0,
    parameter int STARVE_TH  = 8,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*W-1:0]         loc_i,
    output logic [LANES*W-1:0]         loc_o,
    input  logic [LANES*W-1:0]         glb_i,
    output logic [LANES*W-1:0]         glb_o,
    output logic [2*LANES-1:0]         starve_o,
    output logic [2*LANES*CNT_W-1:0]   defl_cnt_o
);
    localparam int NF = 2 * LANES;
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_TH + 1);
    localparam logic [PW:0]         FULL_CNT   = (PW+1)'(DEPTH);
    localparam logic [SW-1:0]       STARVE_MAX = SW'(STARVE_TH);
    localparam logic [RING_W-1:0]   LOCAL_ID   = RING_W'(LOCAL_RING);

    // FIFO index f: 0..LANES-1 are up (local->global), LANES..NF-1 are down (global->local)
    logic [W-1:0]       mem_q    [NF][DEPTH];
    logic [W-1:0]       mem_d    [NF][DEPTH];
    logic [PW-1:0]      wr_q     [NF];
    logic [PW-1:0]      wr_d     [NF];
    logic [PW-1:0]      rd_q     [NF];
    logic [PW-1:0]      rd_d     [NF];
    logic [PW:0]        cnt_q    [NF];
    logic [PW:0]        cnt_d    [NF];
    logic [SW-1:0]      starve_q [NF];
    logic [SW-1:0]      starve_d [NF];
    logic [CNT_W-1:0]   defl_q   [NF];
    logic [CNT_W-1:0]   defl_d   [NF];
    logic [LANES*W-1:0] loc_o_q, loc_o_d;
    logic [LANES*W-1:0] glb_o_q, glb_o_d;

    logic [W-1:0]       arr [NF];
    logic [W-1:0]       res [NF];
    logic [NF-1:0]      want, acc, deq;

    always_comb begin
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        defl_d   = defl_q;
        loc_o_d  = '0;
        glb_o_d  = '0;
        want     = '0;
        acc      = '0;
        deq      = '0;
        for (int f = 0; f < NF; f++) begin
            arr[f] = '0;
            res[f] = '0;
        end

        for (int k = 0; k < LANES; k++) begin
            arr[k]       = loc_i[k*W +: W];
            arr[LANES+k] = glb_i[k*W +: W];
        end

        // res is whatever stays on the arrival ring: pass-through or deflected flits
        for (int f = 0; f < NF; f++) begin
            if (f < LANES)
                want[f] = arr[f][0] && (arr[f][DST_LSB +: RING_W] != LOCAL_ID);
            else
                want[f] = arr[f][0] && (arr[f][DST_LSB +: RING_W] == LOCAL_ID);
            acc[f] = want[f] && (cnt_q[f] < FULL_CNT);
            res[f] = (arr[f][0] && !acc[f]) ? arr[f] : '0;
            if (want[f] && !acc[f] && (defl_q[f] != '1))
                defl_d[f] = defl_q[f] + CNT_W'(1);
        end

        for (int k = 0; k < LANES; k++) begin
            deq[k]       = (cnt_q[k] != '0) && !res[LANES+k][0];
            deq[LANES+k] = (cnt_q[LANES+k] != '0) && !res[k][0];
            glb_o_d[k*W +: W] = deq[k] ? mem_q[k][rd_q[k]] : res[LANES+k];
            loc_o_d[k*W +: W] = deq[LANES+k] ? mem_q[LANES+k][rd_q[LANES+k]] : res[k];
        end

        for (int f = 0; f < NF; f++) begin
            if (acc[f]) begin
                mem_d[f][wr_q[f]] = arr[f];
                wr_d[f] = wr_q[f] + PW'(1);
            end
            if (deq[f])
                rd_d[f] = rd_q[f] + PW'(1);
            cnt_d[f] = cnt_q[f] + (PW+1)'(acc[f]) - (PW+1)'(deq[f]);
            if ((cnt_q[f] == '0) || deq[f])
                starve_d[f] = '0;
            else if (starve_q[f] != STARVE_MAX)
                starve_d[f] = starve_q[f] + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NF; f++) begin
                wr_q[f]     <= '0;
                rd_q[f]     <= '0;
                cnt_q[f]    <= '0;
                starve_q[f] <= '0;
                defl_q[f]   <= '0;
            end
            loc_o_q <= '0;
            glb_o_q <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            defl_q   <= defl_d;
            loc_o_q  <= loc_o_d;
            glb_o_q  <= glb_o_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is live
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign loc_o = loc_o_q;
    assign glb_o = glb_o_q;

    always_comb begin
        starve_o   = '0;
        defl_cnt_o = '0;
        for (int f = 0; f < NF; f++) begin
            starve_o[f]                   = (starve_q[f] >= STARVE_MAX);
            defl_cnt_o[f*CNT_W +: CNT_W]  = defl_q[f];
        end
    end
endmodule

// File: tb/tb_hr_bridge_param.sv
// Self-checking bench for hr_bridge_param: directed ring scenarios followed by random traffic,
// every cycle compared against a queue-style behavioural model of the bridge.
`timescale 1ns/1ps
module tb_hr_bridge_param;
    localparam int W          = 144;
    localparam int LANES      = 2;
    localparam int DEPTH      = 4;
    localparam int RING_W     = 4;
    localparam int DST_LSB    = 4;
    localparam int LOCAL_RING = 0;
    localparam int STARVE_TH  = 8;
    localparam int CNT_W      = 16;
    localparam int NF         = 2 * LANES;
    localparam int DEFL_MAX   = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [LANES*W-1:0]       loc_i, glb_i, loc_o, glb_o;
    logic [NF-1:0]            starve_o;
    logic [NF*CNT_W-1:0]      defl_cnt_o;

    hr_bridge_param #(
        .W(W), .LANES(LANES), .DEPTH(DEPTH), .RING_W(RING_W), .DST_LSB(DST_LSB),
        .LOCAL_RING(LOCAL_RING), .STARVE_TH(STARVE_TH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .loc_i(loc_i), .loc_o(loc_o),
        .glb_i(glb_i), .glb_o(glb_o),
        .starve_o(starve_o), .defl_cnt_o(defl_cnt_o)
    );

    always #5 clk = ~clk;

    // Model: each FIFO is a list whose element 0 is the oldest flit
    logic [W-1:0]       mFifo   [NF][DEPTH];
    int                 mCount  [NF];
    int                 mStarve [NF];
    int                 mDefl   [NF];
    logic [LANES*W-1:0] expLoc, expGlb;
    int                 checkCount = 0;
    int                 passCount  = 0;
    int                 failCount  = 0;

    function automatic logic [W-1:0] makeFlit(input bit valid, input int dst);
        logic [159:0] raw;
        logic [W-1:0] f;
        raw = {$urandom, $urandom, $urandom, $urandom, $urandom};
        f = raw[W-1:0];
        f[0] = valid;
        f[DST_LSB +: RING_W] = RING_W'(dst);
        return f;
    endfunction

    function automatic logic [LANES*W-1:0] onLane(input int k, input logic [W-1:0] f);
        logic [LANES*W-1:0] v;
        v = '0;
        v[k*W +: W] = f;
        return v;
    endfunction

    task automatic modelClear();
        for (int f = 0; f < NF; f++) begin
            mCount[f]  = 0;
            mStarve[f] = 0;
            mDefl[f]   = 0;
        end
        expLoc = '0;
        expGlb = '0;
    endtask

    task automatic modelStep(input logic [LANES*W-1:0] li, input logic [LANES*W-1:0] gi);
        logic [W-1:0] inFlit [NF];
        logic [W-1:0] resid  [NF];
        logic [W-1:0] outSlot;
        bit           accept [NF];
        bit           across;
        bit           popped;
        int           dest;
        int           other;
        expLoc = '0;
        expGlb = '0;
        for (int k = 0; k < LANES; k++) begin
            inFlit[k]       = li[k*W +: W];
            inFlit[LANES+k] = gi[k*W +: W];
        end
        for (int f = 0; f < NF; f++) begin
            dest = int'(inFlit[f][DST_LSB +: RING_W]);
            if (f < LANES) across = inFlit[f][0] && (dest != LOCAL_RING);
            else           across = inFlit[f][0] && (dest == LOCAL_RING);
            accept[f] = across && (mCount[f] < DEPTH);
            resid[f]  = (inFlit[f][0] && !accept[f]) ? inFlit[f] : '0;
            if (across && !accept[f] && mDefl[f] < DEFL_MAX) mDefl[f]++;
        end
        for (int f = 0; f < NF; f++) begin
            other   = (f < LANES) ? f + LANES : f - LANES;
            popped  = (mCount[f] > 0) && !resid[other][0];
            outSlot = popped ? mFifo[f][0] : resid[other];
            if (f < LANES) expGlb[f*W +: W] = outSlot;
            else           expLoc[(f-LANES)*W +: W] = outSlot;
            if (mCount[f] == 0 || popped) mStarve[f] = 0;
            else if (mStarve[f] < STARVE_TH) mStarve[f]++;
            if (popped) begin
                for (int i = 0; i < DEPTH - 1; i++) mFifo[f][i] = mFifo[f][i+1];
                mCount[f]--;
            end
            if (accept[f]) begin
                mFifo[f][mCount[f]] = inFlit[f];
                mCount[f]++;
            end
        end
    endtask

    task automatic checkOutput();
        logic [NF-1:0]       expStarve;
        logic [NF*CNT_W-1:0] expDefl;
        for (int f = 0; f < NF; f++) begin
            expStarve[f] = (mStarve[f] >= STARVE_TH);
            expDefl[f*CNT_W +: CNT_W] = CNT_W'(mDefl[f]);
        end
        checkCount++;
        assert (loc_o === expLoc) passCount++;
        else begin failCount++; $error("[TB] FAIL loc_o got %h exp %h", loc_o, expLoc); end
        checkCount++;
        assert (glb_o === expGlb) passCount++;
        else begin failCount++; $error("[TB] FAIL glb_o got %h exp %h", glb_o, expGlb); end
        checkCount++;
        assert (starve_o === expStarve) passCount++;
        else begin failCount++; $error("[TB] FAIL starve_o got %b exp %b", starve_o, expStarve); end
        checkCount++;
        assert (defl_cnt_o === expDefl) passCount++;
        else begin failCount++; $error("[TB] FAIL defl_cnt_o got %h exp %h", defl_cnt_o, expDefl); end
    endtask

    task automatic checkValue(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checkCount++;
        assert (got === exp) passCount++;
        else begin failCount++; $error("[TB] FAIL %s got %h exp %h", tag, got, exp); end
    endtask

    task automatic applyStimulus(input logic [LANES*W-1:0] li, input logic [LANES*W-1:0] gi);
        loc_i = li;
        glb_i = gi;
        modelStep(li, gi);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyReset(input logic [LANES*W-1:0] li, input logic [LANES*W-1:0] gi);
        rst   = 1'b1;
        loc_i = li;
        glb_i = gi;
        modelClear();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;
    endtask

    logic [W-1:0]       flitA, flitB, flitC;
    logic [LANES*W-1:0] li, gi;
    int                 density, dsel;

    initial begin
        applyReset('0, '0);

        // Pass-through on local lane 0
        flitA = makeFlit(1'b1, 0);
        applyStimulus(onLane(0, flitA), '0);
        checkValue("pass_loc0", loc_o[0 +: W], flitA);
        checkValue("pass_glb_idle", glb_o[0 +: W], '0);

        // Up transfer on lane 1: slot empties, flit appears on global two cycles later
        flitA = makeFlit(1'b1, 3);
        applyStimulus(onLane(1, flitA), '0);
        checkValue("up_slot_empty", loc_o[W +: W], '0);
        applyStimulus('0, '0);
        checkValue("up_arrive", glb_o[W +: W], flitA);

        // Fill up FIFO lane 0 while global lane 0 is busy, then deflect the fifth
        for (int i = 0; i < 5; i++) begin
            flitA = makeFlit(1'b1, 3);
            applyStimulus(onLane(0, flitA), onLane(0, makeFlit(1'b1, 2)));
        end
        checkValue("deflected_flit", loc_o[0 +: W], flitA);
        checkValue("defl_up0", W'(defl_cnt_o[0 +: CNT_W]), W'(1));
        for (int i = 0; i < 5; i++) applyStimulus('0, '0);

        // Starvation of down FIFO lane 0 behind continuous local pass-through
        flitB = makeFlit(1'b1, 0);
        applyStimulus(onLane(0, makeFlit(1'b1, 0)), onLane(0, flitB));
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(onLane(0, makeFlit(1'b1, 0)), '0);
            if (i == 7) checkValue("starve_before_th", W'(starve_o[LANES]), W'(0));
            if (i == 8) checkValue("starve_at_th", W'(starve_o[LANES]), W'(1));
        end
        applyStimulus('0, '0);
        checkValue("starve_inject", loc_o[0 +: W], flitB);
        checkValue("starve_clear", W'(starve_o[LANES]), W'(0));

        // Same-cycle swap on lane 1
        flitB = makeFlit(1'b1, 0);
        applyStimulus(onLane(1, makeFlit(1'b1, 0)), onLane(1, flitB));
        flitC = makeFlit(1'b1, 3);
        applyStimulus(onLane(1, flitC), '0);
        checkValue("swap_down_head", loc_o[W +: W], flitB);
        applyStimulus('0, '0);
        checkValue("swap_up_arrive", glb_o[W +: W], flitC);

        // Reset with three flits queued
        for (int i = 0; i < 3; i++)
            applyStimulus(onLane(0, makeFlit(1'b1, 5)), onLane(0, makeFlit(1'b1, 1)));
        applyReset('0, '0);
        checkValue("rst_defl", W'(defl_cnt_o), '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, '0);
            checkValue("rst_no_stale", W'(glb_o), '0);
        end

        // Random traffic with varying density and occasional reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            density = (cyc / 100 % 3 == 0) ? 30 : ((cyc / 100 % 3 == 1) ? 65 : 95);
            li = '0;
            gi = '0;
            for (int k = 0; k < LANES; k++) begin
                dsel = int'($urandom_range(0, 3));
                li[k*W +: W] = makeFlit($urandom_range(0, 99) < density,
                                        (dsel < 2) ? 0 : ((dsel == 2) ? 1 : 3));
                dsel = int'($urandom_range(0, 3));
                gi[k*W +: W] = makeFlit($urandom_range(0, 99) < density,
                                        (dsel < 2) ? 0 : ((dsel == 2) ? 2 : 7));
            end
            if ($urandom_range(0, 199) == 0) applyReset(li, gi);
            else                            applyStimulus(li, gi);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
